// File: rtl/io_trap_sequencer.sv
// io_trap_sequencer
//   Tracks Z80 bus cycles for the NABU MegaMapper register file and I/O trap.
//   Generates the opcode-capture, ISR-readback and control-write strobes, and
//   detects writes (and optionally reads) to a protected I/O port range. A
//   violation sets a sticky flag and issues a timed NMI. The trap re-arms once
//   the handler reads the ISR port.
//
//   Optional feature macro: IO_READ_TRAP_EN (when defined, IN cycles to a
//   protected port trap exactly like OUT cycles).
//
// Ports
//   clk, reset_n             clock / async active-low reset
//   m1_n, mreq_n, iorq_n,    Z80 bus controls, synchronous to clk
//   rd_n, wr_n
//   addr[7:0]                Z80 A[7:0]
//   trap_en                  control register bit 0
//   record_isr_en            opcode capture enable (registered)
//   read_isr_en              ISR readback enable (registered)
//   write_ctrl_en            control register write enable (registered)
//   io_violation_occured     sticky violation flag
//   nmi_n                    NMI to the Z80, active-low
module io_trap_sequencer #(
  parameter logic [7:0]  CTRL_PORT = 8'h40,
  parameter logic [7:0]  ISR_PORT  = 8'h41,
  parameter logic [7:0]  PROT_LO   = 8'h00,
  parameter logic [7:0]  PROT_HI   = 8'hFF,
  parameter int unsigned NMI_WIDTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       m1_n,
  input  logic       mreq_n,
  input  logic       iorq_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] addr,
  input  logic       trap_en,
  output logic       record_isr_en,
  output logic       read_isr_en,
  output logic       write_ctrl_en,
  output logic       io_violation_occured,
  output logic       nmi_n
);

  typedef enum logic [2:0] {BUS_IDLE, BUS_FETCH, BUS_IOR, BUS_IOW, BUS_INTA} bus_t;
  typedef enum logic [1:0] {TRAP_ARMED, TRAP_PULSE, TRAP_PENDING} trap_t;

  localparam logic [3:0] NMI_LOAD  = 4'(NMI_WIDTH - 1);
  localparam logic [8:0] PROT_SPAN = {1'b0, PROT_HI} - {1'b0, PROT_LO};

  bus_t       r_bus, w_bus_nxt;
  trap_t      r_trap, w_trap_nxt;
  logic [7:0] r_addr, w_addr_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_record, r_read, r_write, r_flag, r_nmi_n;

  logic       w_cyc_done, w_io_entry, w_trap_cyc, w_in_range;
  logic       w_viol, w_isr_clr;
  logic [8:0] w_off;

  // ---------------------------------------------------------------- bus FSM
  // The edge that ends a cycle also evaluates the cycle-start conditions, so a
  // new cycle whose controls are already asserted on that edge is not lost.
  always_comb begin
    w_cyc_done = 1'b1;
    case (r_bus)
      BUS_FETCH, BUS_INTA: w_cyc_done = m1_n;
      BUS_IOR:             w_cyc_done = rd_n;
      BUS_IOW:             w_cyc_done = wr_n;
      default:             w_cyc_done = 1'b1;
    endcase

    w_bus_nxt = r_bus;
    if (w_cyc_done) begin
      if (!m1_n && !mreq_n)       w_bus_nxt = BUS_FETCH;
      else if (!m1_n && !iorq_n)  w_bus_nxt = BUS_INTA;
      else if (!iorq_n && !rd_n)  w_bus_nxt = BUS_IOR;
      else if (!iorq_n && !wr_n)  w_bus_nxt = BUS_IOW;
      else                        w_bus_nxt = BUS_IDLE;
    end
  end

  assign w_io_entry = w_cyc_done && ((w_bus_nxt == BUS_IOR) || (w_bus_nxt == BUS_IOW));
  assign w_addr_nxt = w_io_entry ? addr : r_addr;

  // ---------------------------------------------------------- violation check
  // Range test as an offset compare; the 9-bit width keeps addresses below
  // PROT_LO out of range after the wrap.
  assign w_off      = {1'b0, addr} - {1'b0, PROT_LO};
  assign w_in_range = (w_off <= PROT_SPAN);

`ifdef IO_READ_TRAP_EN
  assign w_trap_cyc = (w_bus_nxt == BUS_IOW) || (w_bus_nxt == BUS_IOR);
`else
  assign w_trap_cyc = (w_bus_nxt == BUS_IOW);
`endif

  assign w_viol = w_io_entry && w_trap_cyc && trap_en && w_in_range &&
                  (addr != CTRL_PORT) && (addr != ISR_PORT);

  // ISR read completes on the IOR exit edge.
  assign w_isr_clr = (r_bus == BUS_IOR) && rd_n && (r_addr == ISR_PORT);

  // --------------------------------------------------------------- trap FSM
  always_comb begin
    w_trap_nxt = r_trap;
    w_cnt_nxt  = r_cnt;
    case (r_trap)
      TRAP_ARMED: begin
        if (w_viol) begin
          w_trap_nxt = TRAP_PULSE;
          w_cnt_nxt  = NMI_LOAD;
        end
      end
      TRAP_PULSE: begin
        if (r_cnt == 4'd0) w_trap_nxt = TRAP_PENDING;
        else               w_cnt_nxt  = r_cnt - 4'd1;
      end
      TRAP_PENDING: begin
        // A violation on the clearing edge re-triggers instead of re-arming.
        if (w_isr_clr) begin
          if (w_viol) begin
            w_trap_nxt = TRAP_PULSE;
            w_cnt_nxt  = NMI_LOAD;
          end else begin
            w_trap_nxt = TRAP_ARMED;
          end
        end
      end
      default: w_trap_nxt = TRAP_ARMED;
    endcase
  end

  // -------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bus    <= BUS_IDLE;
      r_trap   <= TRAP_ARMED;
      r_addr   <= 8'h00;
      r_cnt    <= 4'd0;
      r_record <= 1'b0;
      r_read   <= 1'b0;
      r_write  <= 1'b0;
      r_flag   <= 1'b0;
      r_nmi_n  <= 1'b1;
    end else begin
      r_bus    <= w_bus_nxt;
      r_trap   <= w_trap_nxt;
      r_addr   <= w_addr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_record <= (w_bus_nxt == BUS_FETCH) && (w_trap_nxt == TRAP_ARMED);
      r_read   <= (w_bus_nxt == BUS_IOR) && (w_addr_nxt == ISR_PORT);
      r_write  <= (w_bus_nxt == BUS_IOW) && (w_addr_nxt == CTRL_PORT);
      r_flag   <= (w_trap_nxt != TRAP_ARMED);
      r_nmi_n  <= (w_trap_nxt != TRAP_PULSE);
    end
  end

  assign record_isr_en        = r_record;
  assign read_isr_en          = r_read;
  assign write_ctrl_en        = r_write;
  assign io_violation_occured = r_flag;
  assign nmi_n                = r_nmi_n;

endmodule
